gpio_pad_bank: RTL and testbench

GPIO_PAD_BANK -- requirements
Module: gpio_pad_bank

---
 rtl/gpio_pad_bank.sv | 183 ++++++++++++++++++
 tb/tb_gpio_pad_bank.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/gpio_pad_bank.sv
// GPIO pad bank: Wishbone register file, pad drive muxing, synchronised and
// glitch-filtered inputs, and per-channel rise/fall edge interrupts.
module gpio_pad_bank #(
  parameter int WIDTH       = 8,
  parameter int FILTER_W    = 4,
  parameter int FILTER_INIT = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [2:0]       i_wb_adr,
  input  logic [31:0]      i_wb_dat,
  input  logic [3:0]       i_wb_sel,
  input  logic             i_wb_we,
  input  logic             i_wb_cyc,
  input  logic             i_wb_stb,
  output logic [31:0]      o_wb_rdt,
  output logic             o_wb_ack,
  input  logic [WIDTH-1:0] i_pad,
  output logic [WIDTH-1:0] o_pad,
  output logic [WIDTH-1:0] o_pad_oe,
  output logic             o_irq
);

  localparam logic [2:0] ADR_IN     = 3'd0;
  localparam logic [2:0] ADR_OUT    = 3'd1;
  localparam logic [2:0] ADR_DIR    = 3'd2;
  localparam logic [2:0] ADR_OD     = 3'd3;
  localparam logic [2:0] ADR_RISE   = 3'd4;
  localparam logic [2:0] ADR_FALL   = 3'd5;
  localparam logic [2:0] ADR_STATUS = 3'd6;
  localparam logic [2:0] ADR_FILTER = 3'd7;

  function automatic logic [WIDTH-1:0] merge_ch(input logic [WIDTH-1:0] old_v,
                                                input logic [31:0] dat,
                                                input logic [3:0] sel);
    logic [WIDTH-1:0] r;
    for (int b = 0; b < WIDTH; b++) r[b] = sel[b / 8] ? dat[b] : old_v[b];
    return r;
  endfunction

  function automatic logic [FILTER_W-1:0] merge_flt(input logic [FILTER_W-1:0] old_v,
                                                    input logic [31:0] dat,
                                                    input logic [3:0] sel);
    logic [FILTER_W-1:0] r;
    for (int b = 0; b < FILTER_W; b++) r[b] = sel[b / 8] ? dat[b] : old_v[b];
    return r;
  endfunction

  function automatic logic [31:0] zext_ch(input logic [WIDTH-1:0] v);
    logic [31:0] r;
    r = 32'd0;
    r[WIDTH-1:0] = v;
    return r;
  endfunction

  function automatic logic [31:0] zext_flt(input logic [FILTER_W-1:0] v);
    logic [31:0] r;
    r = 32'd0;
    r[FILTER_W-1:0] = v;
    return r;
  endfunction

  logic [WIDTH-1:0] out_q, out_d, dir_q, dir_d, od_q, od_d;
  logic [WIDTH-1:0] rise_q, rise_d, fall_q, fall_d, irq_q, irq_d;
  logic [WIDTH-1:0] in_q, in_d, in_prev_q;
  logic [WIDTH-1:0] sync1_q, sync2_q, smp_q;
  logic [WIDTH-1:0][FILTER_W-1:0] cnt_q, cnt_d;
  logic [FILTER_W-1:0] filter_q, filter_d;
  logic             ack_q, ack_d;
  logic [31:0]      rdt_q, rdt_d, rd_mux_s;
  logic             req_s, wr_s, rd_s;
  logic [WIDTH-1:0] w1c_s, rise_ev_s, fall_ev_s;
  logic             unused_s;

  // Upper write-data bits beyond the implemented channels are deliberately dropped.
  assign unused_s = ^i_wb_dat;

  // Bus decode, register writes, read mux and interrupt status update.
  always_comb begin
    req_s    = i_wb_cyc & i_wb_stb & ~ack_q;
    wr_s     = req_s & i_wb_we;
    rd_s     = req_s & ~i_wb_we;
    ack_d    = req_s;
    out_d    = out_q;
    dir_d    = dir_q;
    od_d     = od_q;
    rise_d   = rise_q;
    fall_d   = fall_q;
    filter_d = filter_q;
    w1c_s    = {WIDTH{1'b0}};
    if (wr_s) begin
      case (i_wb_adr)
        ADR_OUT:    out_d    = merge_ch(out_q, i_wb_dat, i_wb_sel);
        ADR_DIR:    dir_d    = merge_ch(dir_q, i_wb_dat, i_wb_sel);
        ADR_OD:     od_d     = merge_ch(od_q, i_wb_dat, i_wb_sel);
        ADR_RISE:   rise_d   = merge_ch(rise_q, i_wb_dat, i_wb_sel);
        ADR_FALL:   fall_d   = merge_ch(fall_q, i_wb_dat, i_wb_sel);
        ADR_STATUS: w1c_s    = merge_ch({WIDTH{1'b0}}, i_wb_dat, i_wb_sel);
        ADR_FILTER: filter_d = merge_flt(filter_q, i_wb_dat, i_wb_sel);
        default:    out_d    = out_q;
      endcase
    end else begin
      w1c_s = {WIDTH{1'b0}};
    end
    case (i_wb_adr)
      ADR_IN:     rd_mux_s = zext_ch(in_q);
      ADR_OUT:    rd_mux_s = zext_ch(out_q);
      ADR_DIR:    rd_mux_s = zext_ch(dir_q);
      ADR_OD:     rd_mux_s = zext_ch(od_q);
      ADR_RISE:   rd_mux_s = zext_ch(rise_q);
      ADR_FALL:   rd_mux_s = zext_ch(fall_q);
      ADR_STATUS: rd_mux_s = zext_ch(irq_q);
      ADR_FILTER: rd_mux_s = zext_flt(filter_q);
      default:    rd_mux_s = 32'd0;
    endcase
    rdt_d     = rd_s ? rd_mux_s : 32'd0;
    rise_ev_s = in_q & ~in_prev_q & rise_q;
    fall_ev_s = ~in_q & in_prev_q & fall_q;
    // A set event in the same cycle as a W1C wins.
    irq_d     = (irq_q & ~w1c_s) | rise_ev_s | fall_ev_s;
  end

  // Per-channel glitch filter on the sampled synchroniser output.
  always_comb begin
    in_d  = in_q;
    cnt_d = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (smp_q[i] == in_q[i]) begin
        cnt_d[i] = {FILTER_W{1'b0}};
      end else if (cnt_q[i] == filter_q) begin
        in_d[i]  = smp_q[i];
        cnt_d[i] = {FILTER_W{1'b0}};
      end else begin
        cnt_d[i] = cnt_q[i] + FILTER_W'(1);
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      out_q     <= {WIDTH{1'b0}};
      dir_q     <= {WIDTH{1'b0}};
      od_q      <= {WIDTH{1'b0}};
      rise_q    <= {WIDTH{1'b0}};
      fall_q    <= {WIDTH{1'b0}};
      irq_q     <= {WIDTH{1'b0}};
      in_q      <= {WIDTH{1'b0}};
      in_prev_q <= {WIDTH{1'b0}};
      sync1_q   <= {WIDTH{1'b0}};
      sync2_q   <= {WIDTH{1'b0}};
      smp_q     <= {WIDTH{1'b0}};
      cnt_q     <= {(WIDTH * FILTER_W){1'b0}};
      filter_q  <= FILTER_W'(FILTER_INIT);
      ack_q     <= 1'b0;
      rdt_q     <= 32'd0;
    end else begin
      out_q     <= out_d;
      dir_q     <= dir_d;
      od_q      <= od_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      irq_q     <= irq_d;
      in_q      <= in_d;
      in_prev_q <= in_q;
      sync1_q   <= i_pad;
      sync2_q   <= sync1_q;
      smp_q     <= sync2_q;
      cnt_q     <= cnt_d;
      filter_q  <= filter_d;
      ack_q     <= ack_d;
      rdt_q     <= rdt_d;
    end
  end

  // Open-drain channels only ever pull low: enable the driver when OUT is 0.
  assign o_pad    = out_q & ~od_q;
  assign o_pad_oe = dir_q & ~(od_q & out_q);
  assign o_irq    = |irq_q;
  assign o_wb_ack = ack_q;
  assign o_wb_rdt = rdt_q;

endmodule

// File: tb/tb_gpio_pad_bank.sv
// Directed self-checking bench for gpio_pad_bank (WIDTH=8, FILTER_W=4, FILTER_INIT=3).
module tb_gpio_pad_bank;

  logic        clk;
  logic        rst;
  logic [2:0]  wb_adr;
  logic [31:0] wb_dat;
  logic [3:0]  wb_sel;
  logic        wb_we, wb_cyc, wb_stb;
  logic [31:0] wb_rdt;
  logic        wb_ack;
  logic [7:0]  pad_in, pad_out, pad_oe;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;

  gpio_pad_bank #(.WIDTH(8), .FILTER_W(4), .FILTER_INIT(3)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_wb_adr(wb_adr), .i_wb_dat(wb_dat), .i_wb_sel(wb_sel),
    .i_wb_we(wb_we), .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb),
    .o_wb_rdt(wb_rdt), .o_wb_ack(wb_ack),
    .i_pad(pad_in), .o_pad(pad_out), .o_pad_oe(pad_oe), .o_irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wb_write(input logic [2:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    logic got;
    got = 1'b0;
    wb_adr = adr; wb_dat = dat; wb_sel = sel;
    wb_we = 1'b1; wb_cyc = 1'b1; wb_stb = 1'b1;
    for (int c = 0; c < 4 && !got; c++) begin
      @(posedge clk);
      #1;
      if (wb_ack) got = 1'b1;
    end
    wb_we = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0;
    check_eq("wr_ack", {31'd0, got}, 32'd1);
  endtask

  task automatic wb_read(input logic [2:0] adr, output logic [31:0] d);
    logic got;
    got = 1'b0;
    d = 32'hDEAD_BEEF;
    wb_adr = adr; wb_dat = 32'd0; wb_sel = 4'hF;
    wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1;
    for (int c = 0; c < 4 && !got; c++) begin
      @(posedge clk);
      #1;
      if (wb_ack) begin
        got = 1'b1;
        d = wb_rdt;
      end
    end
    wb_cyc = 1'b0; wb_stb = 1'b0;
    check_eq("rd_ack", {31'd0, got}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    rst = 1'b1; pad_in = 8'h00;
    wb_adr = 3'd7; wb_dat = 32'd0; wb_sel = 4'hF;
    wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1;

    // Reset with a read strobe held through release.
    tick(3);
    check_eq("rst_ack", wb_ack, 1'b0);
    check_eq("rst_rdt", wb_rdt, 32'd0);
    check_eq("rst_pad", pad_out, 8'h00);
    check_eq("rst_oe", pad_oe, 8'h00);
    check_eq("rst_irq", irq, 1'b0);
    rst = 1'b0;
    tick(1);
    check_eq("rel_ack1", wb_ack, 1'b1);
    check_eq("rel_rdt", wb_rdt, 32'd3);
    tick(1);
    check_eq("rel_ack_gap", wb_ack, 1'b0);
    tick(1);
    check_eq("rel_ack2", wb_ack, 1'b1);
    wb_cyc = 1'b0; wb_stb = 1'b0;

    for (int a = 0; a < 8; a++) begin
      wb_read(3'(a), d);
      check_eq($sformatf("reset_rd%0d", a), d, (a == 7) ? 32'd3 : 32'd0);
    end
    check_eq("reset_oe", pad_oe, 8'h00);

    // Pad drive: push-pull on high nibble, open-drain on low nibble.
    wb_write(3'd2, 32'h0000_00FF, 4'hF);
    wb_write(3'd1, 32'h0000_00A5, 4'hF);
    wb_write(3'd3, 32'h0000_000F, 4'hF);
    check_eq("pad_in_ack_cycle", pad_out, 8'hA0);
    check_eq("oe_in_ack_cycle", pad_oe, 8'hFA);
    wb_read(3'd1, d); check_eq("rd_out", d, 32'hA5);

    // Unimplemented bits read 0.
    wb_write(3'd1, 32'hFFFF_FFFF, 4'hF);
    wb_read(3'd1, d); check_eq("out_upper", d, 32'h0000_00FF);
    wb_write(3'd7, 32'hFFFF_FFFF, 4'hF);
    wb_read(3'd7, d); check_eq("filter_upper", d, 32'h0000_000F);
    wb_write(3'd7, 32'h0000_0003, 4'hF);
    wb_write(3'd0, 32'h0000_00FF, 4'hF);
    wb_read(3'd0, d); check_eq("in_ro", d, 32'h0);

    // Byte lane 1 does not reach an 8-bit register.
    wb_write(3'd1, 32'h0000_5A00, 4'b0010);
    wb_read(3'd1, d); check_eq("sel_lane1", d, 32'h0000_00FF);

    // 3-cycle pulse rejected with FILTER=3.
    wb_write(3'd4, 32'h0000_0001, 4'hF);
    pad_in[0] = 1'b1;
    tick(3);
    pad_in[0] = 1'b0;
    tick(12);
    check_eq("pulse_irq", irq, 1'b0);
    wb_read(3'd0, d); check_eq("pulse_in", d, 32'h0);

    // Stable rise before edge k: IN at k+6, interrupt at k+7.
    pad_in[0] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick(1);
      check_eq($sformatf("rise_irq_k%0d", c), irq, (c >= 7) ? 1'b1 : 1'b0);
    end
    wb_read(3'd6, d); check_eq("status_rise", d, 32'h01);
    wb_read(3'd0, d); check_eq("in_rise", d, 32'h01);
    wb_write(3'd6, 32'h0000_0001, 4'hF);
    check_eq("w1c_irq", irq, 1'b0);

    // W1C collides with the filtered fall event of pad[1].
    pad_in[1] = 1'b1;
    tick(12);
    wb_write(3'd5, 32'h0000_0002, 4'hF);
    check_eq("pad1_rise_noirq", irq, 1'b0);
    pad_in[1] = 1'b0;
    tick(7);
    wb_write(3'd6, 32'h0000_0002, 4'hF);
    check_eq("collide_irq", irq, 1'b1);
    wb_read(3'd6, d); check_eq("collide_status", d, 32'h02);
    wb_write(3'd5, 32'h0000_0000, 4'hF);
    wb_read(3'd6, d); check_eq("disable_keeps", d, 32'h02);
    wb_write(3'd6, 32'h0000_0002, 4'hF);
    wb_read(3'd6, d); check_eq("status_clear", d, 32'h0);
    check_eq("irq_clear", irq, 1'b0);

    // Reset asserted mid-write drops the cycle.
    check_eq("pre_rst_pad", pad_out, 8'hF0);
    wb_adr = 3'd1; wb_dat = 32'd0; wb_sel = 4'hF;
    wb_we = 1'b1; wb_cyc = 1'b1; wb_stb = 1'b1;
    rst = 1'b1;
    tick(1);
    check_eq("midrst_ack", wb_ack, 1'b0);
    check_eq("midrst_pad", pad_out, 8'h00);
    check_eq("midrst_oe", pad_oe, 8'h00);
    wb_we = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0;
    tick(1);
    rst = 1'b0;
    wb_read(3'd0, d); check_eq("post_rst_in", d, 32'h0);
    tick(12);
    check_eq("post_rst_noirq", irq, 1'b0);
    wb_read(3'd0, d); check_eq("post_rst_in_set", d, 32'h01);
    wb_read(3'd1, d); check_eq("post_rst_out", d, 32'h0);
    wb_read(3'd7, d); check_eq("post_rst_filter", d, 32'h3);

    // FILTER=0: IN at k+3, interrupt at k+4.
    wb_write(3'd4, 32'h0000_0004, 4'hF);
    wb_write(3'd7, 32'h0000_0000, 4'hF);
    pad_in[2] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick(1);
      check_eq($sformatf("f0_irq_k%0d", c), irq, (c >= 4) ? 1'b1 : 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
